rls_gain_apply: RTL
===================

Name: rls_gain_apply

Overview:
- Consumes the constant gain matrix K (M rows × N columns, nBits signed fixed-point) produced by the gain-matrix block.
- Computes the RLS correction vector y = K·e, where e is the N-element error vector from the error stage.
- Uses one shared multiply-accumulate unit over M·N cycles, with valid/ready handshakes on both sides.
- Sits between the gain-matrix/error stages and the coefficient-update stage.

Parameters:
- nBits, 32, element width; signed two's complement.
- M, 32, rows of K and length of y.
- N, 16, columns of K and length of e.
- FRAC, 8, fractional bits of every K, e and y element.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- K  in  M*N*nBits  gain matrix. Element (i,j) is at bits [(i*N+j)*nBits +: nBits]. Must stay stable while busy.
- e_in  in  N*nBits  error vector. Element j is at bits [j*nBits +: nBits].
- in_valid  in  1  e_in is valid.
- in_ready  out  1  block accepts e_in.
- y_out  out  M*nBits  result vector. Element i is at bits [i*nBits +: nBits].
- out_valid  out  1  y_out is valid.
- out_ready  in  1  downstream accepts y_out.

Behaviour:
- Reset values: in_ready=1, out_valid=0, y_out=0. Internal state: FSM=IDLE, row=0, col=0, acc=0.
- FSM has three states:
  - IDLE: in_ready=1. On in_valid&in_ready, latch e_in into an internal register, clear row/col/acc, go to RUN.
  - RUN: in_ready=0. Each cycle, acc += K(row,col)*e(col).
    - Product is signed, 2*nBits wide. acc width is 2*nBits+clog2(N), so it never overflows.
    - When col==N-1: write sat(acc>>>FRAC) into y_out element row, clear acc, col=0, row++.
    - When row==M-1 and col==N-1: go to DONE.
  - DONE: out_valid=1. y_out is held stable until out_valid&out_ready. On that handshake, go to IDLE and clear out_valid.
- Latency: input handshake on cycle t gives out_valid=1 on cycle t+M*N+1; defaults give 513.
- Throughput: one vector per M*N+2 cycles. One bubble cycle in IDLE; no input is accepted during RUN or DONE.
- Shift: arithmetic right shift (floor toward −∞) unless SAT_ROUND_EN is defined.
- Saturation:
  - If the shifted value > 2^(nBits-1)−1, output 0x7FFF_FFFF (nBits=32).
  - If the shifted value < −2^(nBits-1), output 0x8000_0000.
- y_out elements not yet written in a run hold their values from the previous run. Software reads only on out_valid.
- e_in changing after the handshake has no effect; the latched copy is used.
- in_valid during RUN/DONE is ignored and must be held by the source.
- rst_n asserted mid-RUN or mid-DONE aborts immediately: all state returns to reset values and no partial output is flagged.
- out_ready held low in DONE: the block stalls indefinitely with no data change.

Optional Feature:
- Macro: SAT_ROUND_EN.
- Defined: round half up before the shift, i.e. (acc + 2^(FRAC-1))>>>FRAC, then saturate. The rounding add is done at full accumulator width, so it cannot overflow.
- Undefined: plain arithmetic-shift truncation.
- Latency is unchanged in both cases.

Decomposition:
- Shared package rls_pkg holds:
  - FSM state encoding: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Constant function clog2.
  - Derived width constants PRODW=2*nBits and ACCW=2*nBits+clog2(N).
  - Saturation constants MAXV/MINV per nBits.
- Sub-module rls_mac_sat:
  - Combinational signed multiply-add plus the shift/round/saturate path.
  - Inputs: acc, a, b.
  - Outputs: next acc and the saturated nBits result.
  - The top level keeps the FSM, counters, the e register and the y register.

Test Plan:
- Identity column: K = production gain matrix, e = {e0=0x00000100 (1.0), others 0} → y(i) = K(i,0) for all 32 rows. out_valid rises exactly 513 cycles after the input handshake.
- Saturation:
  - K all 0x7FFFFFFF, e all 0x7FFFFFFF → every y = 0x7FFFFFFF.
  - Then e all 0x80000000 → every y = 0x80000000.
- Rounding with K(0,0)=0xFFFFFE80 (−1.5), e0=0x00000001, rest 0 → y(0) = 0xFFFFFFFE (−2) with SAT_ROUND_EN undefined, and 0xFFFFFFFF (−1) with it defined.
- Backpressure: hold out_ready=0 for 20 cycles in DONE → y_out stable, in_ready=0, in_valid pulses ignored. Raise out_ready → one-cycle handshake, then in_ready=1 the next cycle.
- Reset mid-run: assert rst_n=0 at row 5 → same cycle out_valid=0, in_ready=1, y_out=0. After release, a new vector e=all 0x100 with K all 0x100 gives every y = 0x00001000 (16.0).
- Back-to-back vectors with in_valid held high → second handshake occurs exactly one cycle after the first out handshake, and the results of both runs are correct.

Source files
------------

// File: rtl/rls_pkg.sv
// rls_pkg: FSM encoding, width helpers and saturation limits shared by rls_gain_apply.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rls_pkg;

  // Default configuration used by every module and the interface.
  localparam int DEF_NBITS = 32;
  localparam int DEF_M     = 32;
  localparam int DEF_N     = 16;
  localparam int DEF_FRAC  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

  // Full product width of two nb-bit signed operands.
  function automatic int prodw(input int nb);
    return 2 * nb;
  endfunction

  // Accumulator width: n products summed can never overflow it.
  function automatic int accw(input int nb, input int n);
    return 2 * nb + clog2(n);
  endfunction

  // Most positive nb-bit two's complement value, in the low nb bits.
  function automatic logic [63:0] maxv(input int nb);
    return (64'd1 << (nb - 1)) - 64'd1;
  endfunction

  // Most negative nb-bit two's complement value, in the low nb bits.
  function automatic logic [63:0] minv(input int nb);
    return ~maxv(nb);
  endfunction

endpackage

// File: rtl/rls_gain_apply_if.sv
// rls_gain_apply_if: gain matrix, error vector input and correction vector output bundle.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready on the input side, out_valid/out_ready on the output side.
interface rls_gain_apply_if #(
  parameter int nBits = rls_pkg::DEF_NBITS,
  parameter int M     = rls_pkg::DEF_M,
  parameter int N     = rls_pkg::DEF_N
);

  logic [M*N*nBits-1:0] K;
  logic [N*nBits-1:0]   e_in;
  logic                 in_valid;
  logic                 in_ready;
  logic [M*nBits-1:0]   y_out;
  logic                 out_valid;
  logic                 out_ready;

  // Source/sink side: supplies K and e, consumes y.
  modport master (
    output K, e_in, in_valid, out_ready,
    input  in_ready, y_out, out_valid
  );

  // Block side.
  modport slave (
    input  K, e_in, in_valid, out_ready,
    output in_ready, y_out, out_valid
  );

endinterface

// File: rtl/rls_mac_sat.sv
// rls_mac_sat: one signed multiply-accumulate step plus shift/round/saturate of the new sum.
// Latency: 0 cycles (combinational); no backpressure, the caller sequences it.
// SAT_ROUND_EN defined: round half up before the shift; undefined: floor (arithmetic shift).
module rls_mac_sat
  import rls_pkg::*;
#(
  parameter int nBits = DEF_NBITS,
  parameter int N     = DEF_N,
  parameter int FRAC  = DEF_FRAC
) (
  input  logic signed [accw(nBits, N)-1:0] acc,
  input  logic signed [nBits-1:0]          a,
  input  logic signed [nBits-1:0]          b,
  output logic signed [accw(nBits, N)-1:0] acc_next,
  output logic        [nBits-1:0]          sat
);

  localparam int PRODW = prodw(nBits);
  localparam int ACCW  = accw(nBits, N);
  localparam logic [63:0] MAX64 = maxv(nBits);
  localparam logic [63:0] MIN64 = minv(nBits);

  logic signed [PRODW-1:0] prod;
  logic signed [ACCW-1:0]  pre_shift;
  logic signed [ACCW-1:0]  shifted;
  logic                    pos_ovf;
  logic                    neg_ovf;

  // Full-precision product, sign-extended add, then scale back by FRAC and clamp to nBits.
  always_comb begin
    prod     = PRODW'(a) * PRODW'(b);
    acc_next = acc + {{(ACCW-PRODW){prod[PRODW-1]}}, prod};
`ifdef SAT_ROUND_EN
    pre_shift = acc_next + (ACCW'(1) << (FRAC - 1));
`else
    pre_shift = acc_next;
`endif
    shifted = pre_shift >>> FRAC;
    // Out of range when the bits above the nBits sign position disagree with the sign.
    pos_ovf = !shifted[ACCW-1] && (|shifted[ACCW-2:nBits-1]);
    neg_ovf = shifted[ACCW-1] && !(&shifted[ACCW-2:nBits-1]);
    sat     = shifted[nBits-1:0];
    if (pos_ovf) begin
      sat = MAX64[nBits-1:0];
    end else if (neg_ovf) begin
      sat = MIN64[nBits-1:0];
    end
  end

endmodule

// File: rtl/rls_gain_apply.sv
// rls_gain_apply: y = K*e using one shared MAC, walking K row-major over M*N cycles.
// Latency: out_valid rises M*N+1 cycles after the input handshake; one vector per M*N+2 cycles.
// Backpressure: in_ready low while busy; y held in DONE until out_ready. SAT_ROUND_EN picks rounding.
module rls_gain_apply
  import rls_pkg::*;
#(
  parameter int nBits = DEF_NBITS,
  parameter int M     = DEF_M,
  parameter int N     = DEF_N,
  parameter int FRAC  = DEF_FRAC
) (
  input logic            clk,
  input logic            rst_n,
  rls_gain_apply_if.slave bus
);

  localparam int ACCW = accw(nBits, N);
  localparam int RW   = (clog2(M) > 0) ? clog2(M) : 1;
  localparam int CW   = (clog2(N) > 0) ? clog2(N) : 1;
  localparam logic [RW-1:0] LAST_ROW = RW'(M - 1);
  localparam logic [CW-1:0] LAST_COL = CW'(N - 1);

  state_t                  state;
  logic [RW-1:0]           row;
  logic [CW-1:0]           col;
  logic signed [ACCW-1:0]  acc;
  logic signed [ACCW-1:0]  acc_next;
  logic [N*nBits-1:0]      e_reg;
  logic [M*nBits-1:0]      y_reg;
  logic                    in_rdy_q;
  logic                    out_vld_q;
  logic signed [nBits-1:0] k_elem;
  logic signed [nBits-1:0] e_elem;
  logic [nBits-1:0]        sat;

  // Pick the K(row,col) and e(col) operands for this cycle's MAC.
  always_comb begin
    k_elem = bus.K[(int'(row) * N + int'(col)) * nBits +: nBits];
    e_elem = e_reg[int'(col) * nBits +: nBits];
  end

  rls_mac_sat #(
    .nBits (nBits),
    .N     (N),
    .FRAC  (FRAC)
  ) u_mac (
    .acc      (acc),
    .a        (k_elem),
    .b        (e_elem),
    .acc_next (acc_next),
    .sat      (sat)
  );

  // Control FSM with counters, latched e, result vector and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      row       <= '0;
      col       <= '0;
      acc       <= '0;
      e_reg     <= '0;
      y_reg     <= '0;
      in_rdy_q  <= 1'b1;
      out_vld_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && in_rdy_q) begin
            e_reg    <= bus.e_in;
            row      <= '0;
            col      <= '0;
            acc      <= '0;
            in_rdy_q <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          if (col == LAST_COL) begin
            // Row complete: the MAC output already includes this cycle's product.
            y_reg[int'(row) * nBits +: nBits] <= sat;
            acc <= '0;
            col <= '0;
            if (row == LAST_ROW) begin
              row       <= '0;
              out_vld_q <= 1'b1;
              state     <= DONE;
            end else begin
              row <= row + 1'b1;
            end
          end else begin
            acc <= acc_next;
            col <= col + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_vld_q <= 1'b0;
            in_rdy_q  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_vld_q <= 1'b0;
          in_rdy_q  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_rdy_q;
  assign bus.out_valid = out_vld_q;
  assign bus.y_out     = y_reg;

endmodule
